// File: rtl/proj_kmer_minhash_pkg.sv
// Shared constants and types for the k-mer minhash front end and its extender.
package proj_kmer_minhash_pkg;

  localparam int FRAG_SIZE_DEF     = 8;
  localparam int BASE_LEN_DEF      = 2;
  localparam int KMER_SIZE_DEF     = 4;
  localparam int INDICES_COUNT_DEF = 4;
  localparam int INDICE_LEN_DEF    = 3;
  localparam int HASH_W_DEF        = KMER_SIZE_DEF * BASE_LEN_DEF;

  // One argmin position per hash function, entry 0 in the low slot.
  typedef logic [INDICES_COUNT_DEF-1:0][INDICE_LEN_DEF-1:0] indices_t;

  // Per-hash XOR seeds, seed 0 in the low byte.
  localparam logic [INDICES_COUNT_DEF*HASH_W_DEF-1:0] HASH_SEEDS_DEF =
    {8'hAA, 8'h55, 8'hFF, 8'h00};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

endpackage

// File: rtl/proj_min_tracker.sv
// Running minimum / argmin for one hash function; one position per enabled cycle.
module proj_min_tracker #(
  parameter int HASH_W     = 8,
  parameter int INDICE_LEN = 3
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  first,
  input  logic [HASH_W-1:0]     hash,
  input  logic [INDICE_LEN-1:0] pos,
  output logic [INDICE_LEN-1:0] best_idx
);

  logic [HASH_W-1:0]     min_q;
  logic [INDICE_LEN-1:0] idx_q;
  logic                  take;

  // Strict compare so a tie keeps the earlier (lower) position.
  assign take     = first || (hash < min_q);
  assign best_idx = take ? pos : idx_q;

  // Fold the current position into the running minimum.
  always_ff @(posedge clk) begin
    if (en) begin
      if (take) min_q <= hash;
      idx_q <= best_idx;
    end
  end

endmodule

// File: rtl/proj_kmer_minhash.sv
// Scans every k-mer of a fragment, one position per cycle, and reports the
// position of the minimum hash for each seeded hash function.
module proj_kmer_minhash
  import proj_kmer_minhash_pkg::*;
#(
  parameter int FRAG_SIZE     = FRAG_SIZE_DEF,
  parameter int BASE_LEN      = BASE_LEN_DEF,
  parameter int FRAG_LEN_BITS = FRAG_SIZE_DEF * BASE_LEN_DEF,
  parameter int KMER_SIZE     = KMER_SIZE_DEF,
  parameter int INDICES_COUNT = INDICES_COUNT_DEF,
  parameter int INDICE_LEN    = INDICE_LEN_DEF,
  parameter int HASH_W        = HASH_W_DEF,
  parameter logic [INDICES_COUNT*HASH_W-1:0] HASH_SEEDS = HASH_SEEDS_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [FRAG_LEN_BITS-1:0]            in_fragment,
  output logic                                busy,
  output logic [INDICES_COUNT*INDICE_LEN-1:0] out_kmer_indices,
  output logic                                valid_indices
);

  localparam int NPOS = FRAG_SIZE - KMER_SIZE + 1;

  state_t                              state_q, state_d;
  logic [INDICE_LEN-1:0]               pos_q;
  logic [FRAG_LEN_BITS-1:0]            frag_q, frag_sh;
  logic [HASH_W-1:0]                   kmer;
  logic [INDICES_COUNT*INDICE_LEN-1:0] best_idx;
  logic                                accept, scan, last;

  assign accept  = (state_q == IDLE) && start;
  assign scan    = (state_q == SCAN);
  assign last    = scan && (pos_q == INDICE_LEN'(NPOS - 1));
  assign frag_sh = frag_q >> (BASE_LEN * int'(pos_q));
  assign kmer    = frag_sh[HASH_W-1:0];

  assign busy          = (state_q != IDLE);
  assign valid_indices = (state_q == DONE);

  // Next-state: accept only from IDLE, DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, position counter and the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pos_q            <= '0;
      out_kmer_indices <= '0;
    end else begin
      state_q <= state_d;
      if (accept || last) pos_q <= '0;
      else if (scan)      pos_q <= pos_q + INDICE_LEN'(1);
      if (last) out_kmer_indices <= best_idx;
    end
  end

  // Fragment is captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) frag_q <= in_fragment;
  end

  for (genvar j = 0; j < INDICES_COUNT; j++) begin : g_trk
    proj_min_tracker #(.HASH_W(HASH_W), .INDICE_LEN(INDICE_LEN)) u_trk (
      .clk      (clk),
      .en       (scan),
      .first    (pos_q == '0),
      .hash     (kmer ^ HASH_SEEDS[j*HASH_W +: HASH_W]),
      .pos      (pos_q),
      .best_idx (best_idx[j*INDICE_LEN +: INDICE_LEN])
    );
  end

endmodule

// File: tb/tb_proj_kmer_minhash.sv
// Self-checking bench for proj_kmer_minhash (default parameters).
module tb_proj_kmer_minhash;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_fragment = '0;
  logic        busy, valid_indices;
  logic [11:0] out_kmer_indices;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_prev = '0;

  proj_kmer_minhash dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .in_fragment      (in_fragment),
    .busy             (busy),
    .out_kmer_indices (out_kmer_indices),
    .valid_indices    (valid_indices)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frag;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Minhash straight from the definition: slide over 5 positions, XOR seed,
  // keep the first position holding the smallest value.
  function automatic logic [11:0] model(input logic [15:0] f);
    logic [31:0] seeds;
    logic [11:0] r;
    seeds = 32'hAA55FF00;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      int bestv, bestp, h;
      bestv = 256;
      bestp = 0;
      for (int p = 0; p < 5; p++) begin
        h = int'(((f >> (2 * p)) & 16'h00FF) ^ {8'h00, seeds[j*8 +: 8]});
        if (h < bestv) begin
          bestv = h;
          bestp = p;
        end
      end
      r[j*3 +: 3] = 3'(bestp);
    end
    return r;
  endfunction

  // One request; optionally pokes start mid-scan and in the DONE cycle.
  task automatic run_req(input logic [15:0] frag, input logic [11:0] exp,
                         input bit poke_scan, input bit poke_done, input string tag);
    int got;
    got = 0;
    @(negedge clk);
    start = 1'b1;
    in_fragment = frag;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        in_fragment = 16'($urandom);
      end
      if (poke_scan && k == 3) begin
        start = 1'b1;
        in_fragment = ~frag;
      end
      if (poke_scan && k == 4) start = 1'b0;
      if (valid_indices) begin
        got = k;
        break;
      end
      chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
      chk({tag, "_hold_scan"}, 32'(out_kmer_indices), 32'(exp_prev));
    end
    start = 1'b0;
    chk({tag, "_latency"}, got, 6);
    chk({tag, "_indices"}, 32'(out_kmer_indices), 32'(exp));
    if (poke_done) begin
      start = 1'b1;
      in_fragment = ~frag;
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(valid_indices), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    start = 1'b0;
    if (poke_done) begin
      @(negedge clk);
      chk({tag, "_done_drop"}, 32'(busy), 32'd0);
      chk({tag, "_hold_after"}, 32'(out_kmer_indices), 32'(exp));
    end
    exp_prev = exp;
  endtask

  initial begin
    int pulses;
    vecs[0] = '{16'h0000, {3'd0, 3'd0, 3'd0, 3'd0}};
    vecs[1] = '{16'hE4E4, {3'd3, 3'd2, 3'd0, 3'd1}};
    vecs[2] = '{16'hFFFF, {3'd0, 3'd0, 3'd0, 3'd0}};
    vecs[3] = '{16'h00FF, {3'd0, 3'd4, 3'd0, 3'd4}};

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid_indices), 32'd0);
    chk("rst_out", 32'(out_kmer_indices), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(valid_indices), 32'd0);
    chk("idle_out", 32'(out_kmer_indices), 32'd0);

    // Directed table
    for (int i = 0; i < 4; i++) run_req(vecs[i].frag, vecs[i].exp, 1'b0, 1'b0, $sformatf("vec%0d", i));

    // Start poked during SCAN (pos=2) and during DONE
    run_req(16'hE4E4, vecs[1].exp, 1'b1, 1'b1, "poke");

    // Reset at SCAN pos=3 aborts the request
    @(negedge clk);
    start = 1'b1;
    in_fragment = 16'h00FF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid_indices), 32'd0);
    chk("abort_out", 32'(out_kmer_indices), 32'd0);
    exp_prev = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid_indices) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    run_req(16'hE4E4, vecs[1].exp, 1'b0, 1'b0, "after_abort");

    // Randomized fragments against the model
    for (int i = 0; i < 10; i++) begin
      logic [15:0] f;
      f = 16'($urandom);
      run_req(f, model(f), 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    // start held high: accept, 5 scan cycles, DONE, repeating every 7 cycles
    @(negedge clk);
    start = 1'b1;
    in_fragment = 16'hE4E4;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("held_valid_c%0d", k), 32'(valid_indices), 32'((k % 7) == 6));
      chk($sformatf("held_busy_c%0d", k), 32'(busy), 32'((k % 7) != 0));
      if (valid_indices) chk("held_out", 32'(out_kmer_indices), 32'(vecs[1].exp));
    end
    start = 1'b0;
    @(negedge clk);
    chk("held_end_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
